// File: rtl/cadence_stim_pkg.sv
// Shared types and register map for the cadence stimulus generator.
package cadence_stim_pkg;

    // Channel operating mode decoded from CTRL[2:1]; both 10 and 11 mean STOP.
    typedef enum logic [1:0] {
        CONST = 2'd0,
        RAMP  = 2'd1,
        STOP  = 2'd2
    } mode_t;

    // Per-channel waveform state.
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        HIGH = 2'd1,
        LOW  = 2'd2
    } ch_state_t;

    // Configuration register addresses.
    localparam logic [1:0] A_HALF = 2'd0;
    localparam logic [1:0] A_END  = 2'd1;
    localparam logic [1:0] A_STEP = 2'd2;
    localparam logic [1:0] A_CTRL = 2'd3;

    function automatic mode_t decode_mode(input logic [1:0] m);
        return m[1] ? STOP : (m[0] ? RAMP : CONST);
    endfunction

endpackage

// File: rtl/cadence_stim_ch.sv
// One cadence channel: config registers, phase counter, IDLE/HIGH/LOW FSM and
// ramp adder that saturates at END_PER.
module cadence_stim_ch
    import cadence_stim_pkg::*;
#(
    parameter int PER_W  = 24,
    parameter int STEP_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             wr_en,
    input  logic [1:0]       wr_addr,
    input  logic [PER_W-1:0] wr_data,
    output logic             pulse,
    output logic             rise_stb,
    output logic             ramp_done,
    output logic             active
);

    // Two guard bits so the ramp sum can go below zero or above 2^PER_W-1.
    localparam int SW = PER_W + 2;

    logic [PER_W-1:0]         half_per_q;
    logic [PER_W-1:0]         end_per_q;
    logic signed [STEP_W-1:0] step_q;
    mode_t                    mode_q;

    ch_state_t                state_q, state_d;
    logic [PER_W-1:0]         cnt_q, cnt_d;
    logic [PER_W-1:0]         cur_per_q, cur_per_d;
    logic                     rise_q, rise_d;
    logic                     done_q, done_d;

    logic                     ctrl_wr;
    logic                     go;
    logic [PER_W-1:0]         eff_per;
    logic                     term;
    logic signed [SW-1:0]     ramp_sum;
    logic [PER_W:0]           ramp_res;

    // Saturate the ramp sum at the end period; bit PER_W flags that the clamp hit.
    function automatic logic [PER_W:0] ramp_clamp(input logic signed [SW-1:0] sum,
                                                  input logic [PER_W-1:0]     lim,
                                                  input logic                 down);
        logic signed [SW-1:0] lim_s;
        logic                 hit;
        lim_s = $signed({2'b00, lim});
        hit   = down ? (sum <= lim_s) : (sum >= lim_s);
        return hit ? {1'b1, lim} : {1'b0, sum[PER_W-1:0]};
    endfunction

    assign ctrl_wr  = wr_en && (wr_addr == A_CTRL);
    assign go       = wr_data[0] && !wr_data[2];
    assign eff_per  = (cur_per_q == '0) ? PER_W'(1) : cur_per_q;
    assign term     = (cnt_q == eff_per - PER_W'(1));
    assign ramp_sum = $signed({2'b00, cur_per_q})
                    + $signed({{(SW-STEP_W){step_q[STEP_W-1]}}, step_q});
    assign ramp_res = ramp_clamp(ramp_sum, end_per_q, step_q[STEP_W-1]);

    // Configuration register file.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            half_per_q <= '0;
            end_per_q  <= '0;
            step_q     <= '0;
            mode_q     <= CONST;
        end else if (wr_en) begin
            case (wr_addr)
                A_HALF:  half_per_q <= wr_data;
                A_END:   end_per_q  <= wr_data;
                A_STEP:  step_q     <= $signed(wr_data[STEP_W-1:0]);
                default: mode_q     <= decode_mode(wr_data[2:1]);
            endcase
        end
    end

    // Waveform state, counter, current half-period and status flags.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            cur_per_q <= '0;
            rise_q    <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            cur_per_q <= cur_per_d;
            rise_q    <= rise_d;
            done_q    <= done_d;
        end
    end

    // Next state: phase toggles resolve first, then a CTRL write may stop or start.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        cur_per_d = cur_per_q;
        rise_d    = 1'b0;
        done_d    = done_q;
        case (state_q)
            IDLE: begin
                if (ctrl_wr && go) begin
                    state_d   = HIGH;
                    cnt_d     = '0;
                    cur_per_d = half_per_q;
                    rise_d    = 1'b1;
                end
            end
            HIGH: begin
                if (term) begin
                    state_d = LOW;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            LOW: begin
                if (term) begin
                    state_d = HIGH;
                    cnt_d   = '0;
                    rise_d  = 1'b1;
                    if (mode_q == RAMP && step_q != '0) begin
                        cur_per_d = ramp_res[PER_W-1:0];
                        if (ramp_res[PER_W]) begin
                            done_d = 1'b1;
                        end
                    end else begin
                        cur_per_d = half_per_q;
                    end
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
        if (ctrl_wr) begin
            done_d = 1'b0;
            if (!go) begin
                state_d = IDLE;
                cnt_d   = '0;
                rise_d  = 1'b0;
            end
        end
    end

    assign pulse     = (state_q == HIGH);
    assign active    = (state_q != IDLE);
    assign rise_stb  = rise_q;
    assign ramp_done = done_q;

endmodule

// File: rtl/cadence_stim_gen.sv
// Multi-channel cadence stimulus generator: routes config writes to one channel.
module cadence_stim_gen
    import cadence_stim_pkg::*;
#(
    parameter int NUM_CH = 1,
    parameter int PER_W  = 24,
    parameter int STEP_W = 16,
    localparam int CH_W  = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              wr_en,
    input  logic [CH_W-1:0]   wr_ch,
    input  logic [1:0]        wr_addr,
    input  logic [PER_W-1:0]  wr_data,
    output logic [NUM_CH-1:0] pulse,
    output logic [NUM_CH-1:0] rise_stb,
    output logic [NUM_CH-1:0] ramp_done,
    output logic [NUM_CH-1:0] active
);

    // Channel indices with no instance simply never match, so those writes drop.
    for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
        logic ch_wr;
        assign ch_wr = wr_en && (32'(wr_ch) == i);

        cadence_stim_ch #(
            .PER_W  (PER_W),
            .STEP_W (STEP_W)
        ) u_ch (
            .clk       (clk),
            .rst_n     (rst_n),
            .wr_en     (ch_wr),
            .wr_addr   (wr_addr),
            .wr_data   (wr_data),
            .pulse     (pulse[i]),
            .rise_stb  (rise_stb[i]),
            .ramp_done (ramp_done[i]),
            .active    (active[i])
        );
    end

endmodule
